contact_detect_stream: RTL and testbench
========================================

Name: contact_detect_stream

Overview:
- Pipelined, streaming ray–triangle contact detector with closest-hit reduction.
- Accepts one candidate per cycle: barycentrics u, v, determinant det, distance t, triangle id.
- Applies the barycentric, determinant and t-range tests to each candidate and tracks the nearest passing triangle per ray.
- Emits one result per ray when the candidate marked `last` has been reduced. Sits between the intersection arithmetic unit and the shading/ray-queue logic.

Parameters:
- KEPSILON, 32'h322bcc77, det and t lower threshold (1e-8, IEEE-754 single).
- ID_W, 16, triangle id width.
- ADD_LATENCY, 3, cycle latency of the Float_Add instance (must match the IP configuration).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  candidate valid
- in_ready  out  1  candidate accepted when in_valid & in_ready
- u  in  32  barycentric u (float)
- v  in  32  barycentric v (float)
- det  in  32  determinant (float)
- t  in  32  hit distance (float)
- tri_id  in  ID_W  triangle id
- last  in  1  final candidate of current ray
- cull_en  in  1  1 = backface cull, 0 = two-sided; static while a ray is in flight
- t_max  in  32  positive float upper t bound; static while a ray is in flight
- out_valid  out  1  ray result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- hit  out  1  ray has at least one passing triangle
- hit_t  out  32  t of nearest passing triangle (0 if no hit)
- hit_id  out  ID_W  id of nearest passing triangle (0 if no hit)

Behaviour:
- Single clock domain. All outputs, pipeline valids and accumulator state are registered.
- Reset behaviour:
  - Reset is synchronous and active-high.
  - Reset values: out_valid=0, hit=0, hit_t=0, hit_id=0, and the accumulator is empty.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-ray discards all in-flight candidates and any partial accumulation.
- Float compares are local combinational logic:
  - Sign-magnitude is mapped to an ordered integer.
  - -0 equals +0.
  - Any NaN operand forces the candidate to fail.
- Pass condition per candidate (all must hold):
  - u>=0 and v>=0 and u<=1.0
  - (u+v)<=1.0, where u+v comes from the Float_Add instance (a=u, b=v, opSel=1, en=adv, areset=rst)
  - if cull_en=1: det>=KEPSILON; if cull_en=0: |det|>=KEPSILON (sign bit cleared)
  - t>KEPSILON and t<t_max
- Pipeline stages:
  - S0 (capture): registers the inputs and evaluates every test except the sum test.
  - S1..S(ADD_LATENCY): delay line carrying the partial pass flag, t, tri_id and last, aligned with the Float_Add output.
  - SC: sum test, giving the final pass flag.
  - SA: accumulate.
- Accumulator (acc_hit, acc_t, acc_id):
  - Update when pass & (!acc_hit | t < acc_t).
  - Ties keep the earlier triangle (strict less-than).
- On a `last` candidate at SA:
  - Load the output registers with the accumulator value including this candidate's update.
  - Set out_valid=1.
  - Clear the accumulator in the same cycle.
- Flow control:
  - adv = !(out_valid & !out_ready) and in_ready = adv.
  - When adv=0 the whole pipeline holds, including Float_Add via en.
  - A result is accepted and a new result loaded in the same cycle without a bubble.
- Latency and throughput:
  - A `last` candidate accepted in cycle N gives out_valid in cycle N+ADD_LATENCY+2 with no stall.
  - Throughput is one candidate per cycle.
- Pipeline bubbles (in_valid=0) carry valid=0 and never touch the accumulator.
- A single-candidate ray (last=1 on its only candidate) is legal.
- A ray with no passing candidate gives hit=0, hit_t=0, hit_id=0.
- Outputs stay stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset, then a single candidate: u=3e800000 (0.25), v=3f000000 (0.5), det=3f800000, t=40000000 (2.0), id=5, last=1, t_max=42c80000 (100), cull_en=1 -> after ADD_LATENCY+2 cycles: out_valid=1, hit=1, hit_t=40000000, hit_id=5.
2. Boundary pass/fail:
   - u=-0 (80000000), v=0 -> hit.
   - u=3f000000, v=3f19999a (0.6) -> miss (sum>1).
   - u=7fc00000 (NaN) -> miss.
   - u=3f800000, v=0 -> hit.
3. det=bf800000 (-1.0): cull_en=1 -> hit=0; cull_en=0 -> hit=1. det=322bcc76 with cull_en=0 -> miss.
4. Three-candidate ray, back-to-back:
   - t=40400000 (id 1), t=3fc00000 (id 2), t=3fc00000 (id 3, last) -> hit_id=2, hit_t=3fc00000.
   - Then a second ray with t=42c80000 (equal to t_max) -> hit=0.
5. Backpressure: stream 4 single-candidate rays while holding out_ready=0 -> in_ready drops after the first result, no result is lost or duplicated, outputs stay stable. Releasing out_ready drains all 4 in order, one per cycle.
6. Assert rst for one cycle mid-ray after 2 of 3 candidates -> out_valid=0. The next ray's result contains only post-reset candidates.

Source files
------------

// File: rtl/contact_detect_stream_if.sv
// Candidate-in / result-out bus of the ray-triangle contact detector.
// Both directions use valid/ready: a beat transfers on a rising clk edge where valid & ready are high,
// and the source holds valid and its payload steady until that edge.
interface contact_detect_stream_if #(
    parameter int ID_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     u;
    logic [31:0]     v;
    logic [31:0]     det;
    logic [31:0]     t;
    logic [ID_W-1:0] tri_id;
    logic            last;
    logic            cull_en;
    logic [31:0]     t_max;
    logic            out_valid;
    logic            out_ready;
    logic            hit;
    logic [31:0]     hit_t;
    logic [ID_W-1:0] hit_id;

    modport master (
        output in_valid, u, v, det, t, tri_id, last, cull_en, t_max, out_ready,
        input  in_ready, out_valid, hit, hit_t, hit_id
    );

    modport slave (
        input  in_valid, u, v, det, t, tri_id, last, cull_en, t_max, out_ready,
        output in_ready, out_valid, hit, hit_t, hit_id
    );
endinterface

// File: rtl/contact_detect_stream.sv
// Streaming ray-triangle contact detector: per-candidate pass tests, then nearest-hit reduction per ray.
// Float_Add is a pipelined magnitude adder; it is exact up to truncation when both effective signs agree.
module Float_Add #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic        opSel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic [7:0]  ea, eb, el, es, d, e_r;
    logic [23:0] ma, mb, ml, ms;
    logic [24:0] sum;
    logic [22:0] m_r;
    logic        sgn;
    logic [31:0] res_c;
    logic [31:0] pipe [LATENCY];

    always_comb begin
        // Denormals share the exponent of the smallest normal and have no hidden bit.
        ea  = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb  = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma  = {a[30:23] != 8'd0, a[22:0]};
        mb  = {b[30:23] != 8'd0, b[22:0]};
        el  = (eb > ea) ? eb : ea;
        es  = (eb > ea) ? ea : eb;
        ml  = (eb > ea) ? mb : ma;
        ms  = (eb > ea) ? ma : mb;
        d   = el - es;
        sum = {1'b0, ml} + {1'b0, ms >> d};
        sgn = a[31] & (b[31] ^ ~opSel);
        e_r = 8'd0;
        m_r = sum[22:0];
        if (sum[24]) begin
            e_r = el + 8'd1;
            m_r = sum[23:1];
        end else if (sum[23]) begin
            e_r = el;
        end
        if (el >= 8'd254 && sum[24]) begin
            e_r = 8'hff;
            m_r = 23'd0;
        end
        res_c = {sgn, e_r, m_r};
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= 32'd0;
        end else if (en) begin
            pipe[0] <= res_c;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LATENCY-1];
endmodule

module contact_detect_stream #(
    parameter logic [31:0] KEPSILON    = 32'h322bcc77,
    parameter int          ID_W        = 16,
    parameter int          ADD_LATENCY = 3
) (
    input logic                  clk,
    input logic                  rst,
    contact_detect_stream_if.slave io
);
    localparam logic [31:0] F_ZERO = 32'h0000_0000;
    localparam logic [31:0] F_ONE  = 32'h3f80_0000;

    typedef struct packed {
        logic            valid;
        logic            pass;
        logic [31:0]     t;
        logic [ID_W-1:0] id;
        logic            last;
    } stage_t;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hff) && (f[22:0] != 23'd0);
    endfunction

    // Order-preserving unsigned key; -0 is folded onto +0 first.
    function automatic logic [31:0] f_key(input logic [31:0] f);
        logic [31:0] m;
        m = (f == 32'h8000_0000) ? 32'd0 : f;
        return m[31] ? ~m : (m | 32'h8000_0000);
    endfunction

    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        return !is_nan(a) && !is_nan(b) && (f_key(a) < f_key(b));
    endfunction

    function automatic logic f_le(input logic [31:0] a, input logic [31:0] b);
        return !is_nan(a) && !is_nan(b) && (f_key(a) <= f_key(b));
    endfunction

    logic            adv;
    logic [31:0]     s0_u, s0_v, sum_uv, det_mag;
    logic            part_pass, sc_pass, take;
    stage_t          stg [0:ADD_LATENCY];
    logic            acc_hit, nxt_hit, out_valid_r, hit_r;
    logic [31:0]     acc_t, nxt_t, hit_t_r;
    logic [ID_W-1:0] acc_id, nxt_id, hit_id_r;

    assign adv         = !(out_valid_r && !io.out_ready);
    assign io.in_ready = adv;
    assign io.out_valid = out_valid_r;
    assign io.hit      = hit_r;
    assign io.hit_t    = hit_t_r;
    assign io.hit_id   = hit_id_r;

    always_comb begin
        det_mag   = io.cull_en ? io.det : {1'b0, io.det[30:0]};
        part_pass = f_le(F_ZERO, io.u) && f_le(F_ZERO, io.v) && f_le(io.u, F_ONE) &&
                    f_le(KEPSILON, det_mag) && f_lt(KEPSILON, io.t) && f_lt(io.t, io.t_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_u <= 32'd0;
            s0_v <= 32'd0;
            for (int i = 0; i <= ADD_LATENCY; i++) stg[i] <= '0;
        end else if (adv) begin
            s0_u         <= io.u;
            s0_v         <= io.v;
            stg[0].valid <= io.in_valid;
            stg[0].pass  <= part_pass;
            stg[0].t     <= io.t;
            stg[0].id    <= io.tri_id;
            stg[0].last  <= io.last;
            for (int i = 1; i <= ADD_LATENCY; i++) stg[i] <= stg[i-1];
        end
    end

    // Fed from S0 so the sum lines up with the last delay-line stage.
    Float_Add #(.LATENCY(ADD_LATENCY)) u_add (
        .clk    (clk),
        .areset (rst),
        .en     (adv),
        .opSel  (1'b1),
        .a      (s0_u),
        .b      (s0_v),
        .result (sum_uv)
    );

    always_comb begin
        sc_pass = stg[ADD_LATENCY].pass && f_le(sum_uv, F_ONE);
        // Strict less-than keeps the earlier triangle on a tie.
        take    = stg[ADD_LATENCY].valid && sc_pass && (!acc_hit || f_lt(stg[ADD_LATENCY].t, acc_t));
        nxt_hit = acc_hit || take;
        nxt_t   = take ? stg[ADD_LATENCY].t  : acc_t;
        nxt_id  = take ? stg[ADD_LATENCY].id : acc_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hit     <= 1'b0;
            acc_t       <= 32'd0;
            acc_id      <= '0;
            out_valid_r <= 1'b0;
            hit_r       <= 1'b0;
            hit_t_r     <= 32'd0;
            hit_id_r    <= '0;
        end else begin
            if (out_valid_r && io.out_ready) out_valid_r <= 1'b0;
            if (adv && stg[ADD_LATENCY].valid) begin
                if (stg[ADD_LATENCY].last) begin
                    out_valid_r <= 1'b1;
                    hit_r       <= nxt_hit;
                    hit_t_r     <= nxt_t;
                    hit_id_r    <= nxt_id;
                    acc_hit     <= 1'b0;
                    acc_t       <= 32'd0;
                    acc_id      <= '0;
                end else begin
                    acc_hit <= nxt_hit;
                    acc_t   <= nxt_t;
                    acc_id  <= nxt_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_contact_detect_stream.sv
// Directed bench for contact_detect_stream: hand-computed ray results checked through an expected queue.
module tb_contact_detect_stream;
  localparam int ID_W = 16;
  localparam int LAT  = 3;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] exp_q[$];

  contact_detect_stream_if #(.ID_W(ID_W)) bus ();

  contact_detect_stream #(.KEPSILON(32'h322bcc77), .ID_W(ID_W), .ADD_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic h, input logic [31:0] tt, input logic [ID_W-1:0] id);
    return {15'd0, h, tt, id};
  endfunction

  // scoreboard: every accepted result is compared with the head of the queue
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_result", {63'd0, bus.out_valid}, 64'd0);
      else check("result", pk(bus.hit, bus.hit_t, bus.hit_id), exp_q.pop_front());
    end
  end

  // driver tasks: called just after a rising edge, return just after a rising edge
  task automatic send(input logic [31:0] uu, input logic [31:0] vv, input logic [31:0] dd,
                      input logic [31:0] tt, input logic [ID_W-1:0] id, input logic lst,
                      input logic cull);
    int n;
    bus.u = uu; bus.v = vv; bus.det = dd; bus.t = tt;
    bus.tri_id = id; bus.last = lst; bus.cull_en = cull;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic ray(input logic [31:0] uu, input logic [31:0] vv, input logic [31:0] dd,
                     input logic [31:0] tt, input logic [ID_W-1:0] id, input logic cull,
                     input logic eh, input logic [31:0] et, input logic [ID_W-1:0] eid);
    exp_q.push_back(pk(eh, et, eid));
    send(uu, vv, dd, tt, id, 1'b1, cull);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.u = '0; bus.v = '0; bus.det = '0; bus.t = '0;
    bus.tri_id = '0; bus.last = 1'b0; bus.cull_en = 1'b1; bus.t_max = 32'h42c80000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_hit", {63'd0, bus.hit}, 64'd0);
    check("rst_hit_t", {32'd0, bus.hit_t}, 64'd0);
    check("rst_hit_id", {48'd0, bus.hit_id}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // single candidate with latency measurement
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40000000, 16'd5, 1'b1, 1'b1, 32'h40000000, 16'd5);
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT + 2);
    @(posedge clk);
    #1;
    wait_drain();

    // barycentric boundaries
    ray(32'h80000000, 32'h00000000, 32'h3f800000, 32'h40000000, 16'd6, 1'b1, 1'b1, 32'h40000000, 16'd6);
    ray(32'h3f000000, 32'h3f19999a, 32'h3f800000, 32'h40000000, 16'd7, 1'b1, 1'b0, 32'h0, 16'd0);
    ray(32'h7fc00000, 32'h00000000, 32'h3f800000, 32'h40000000, 16'd8, 1'b1, 1'b0, 32'h0, 16'd0);
    ray(32'h3f800000, 32'h00000000, 32'h3f800000, 32'h40000000, 16'd9, 1'b1, 1'b1, 32'h40000000, 16'd9);
    wait_drain();

    // determinant and culling
    ray(32'h3e800000, 32'h3f000000, 32'hbf800000, 32'h40000000, 16'd10, 1'b1, 1'b0, 32'h0, 16'd0);
    ray(32'h3e800000, 32'h3f000000, 32'hbf800000, 32'h40000000, 16'd11, 1'b0, 1'b1, 32'h40000000, 16'd11);
    ray(32'h3e800000, 32'h3f000000, 32'h322bcc76, 32'h40000000, 16'd12, 1'b0, 1'b0, 32'h0, 16'd0);
    wait_drain();

    // three-candidate ray with a tie, then t equal to t_max
    exp_q.push_back(pk(1'b1, 32'h3fc00000, 16'd2));
    send(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40400000, 16'd1, 1'b0, 1'b1);
    send(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h3fc00000, 16'd2, 1'b0, 1'b1);
    send(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h3fc00000, 16'd3, 1'b1, 1'b1);
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h42c80000, 16'd4, 1'b1, 1'b0, 32'h0, 16'd0);
    wait_drain();

    // backpressure: four results queued behind a stalled consumer
    bus.out_ready = 1'b0;
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h3f800000, 16'd20, 1'b1, 1'b1, 32'h3f800000, 16'd20);
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40000000, 16'd21, 1'b1, 1'b1, 32'h40000000, 16'd21);
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40400000, 16'd22, 1'b1, 1'b1, 32'h40400000, 16'd22);
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40800000, 16'd23, 1'b1, 1'b1, 32'h40800000, 16'd23);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("stall_hit_t", {32'd0, bus.hit_t}, 64'h3f800000);
      check("stall_hit_id", {48'd0, bus.hit_id}, 64'd20);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drain_burst", n, 4);
    @(posedge clk);
    #1;
    wait_drain();

    // reset in the middle of a ray discards the partial accumulation
    send(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h3f800000, 16'd30, 1'b0, 1'b1);
    send(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h3f800000, 16'd31, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    ray(32'h3e800000, 32'h3f000000, 32'h3f800000, 32'h40400000, 16'd32, 1'b1, 1'b1, 32'h40400000, 16'd32);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
